// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame constants and loader state encoding
package frame_pkg;

    localparam int FRAME_DEPTH  = 64;
    localparam int FRAME_DATA_W = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        LAST  = 2'd1,
        SUM   = 2'd2,
        READY = 2'd3
    } loader_state_t;

endpackage

// File: rtl/frame_checksum.sv
// rtl/frame_checksum.sv - modulo-2^DATA_W byte accumulator with clear, add-enable and compare
module frame_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    input  logic [DATA_W-1:0] cmp_data,
    output logic              match
);

    logic [DATA_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + add_data;
        end
    end

    assign match = (acc == cmp_data);

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - streams one frame into memory A, holds it until released; FRAME_LOADER_CHECKSUM_EN adds trailing-sum check
module frame_loader
    import frame_pkg::*;
#(
    parameter int DEPTH  = FRAME_DEPTH,
    parameter int DATA_W = FRAME_DATA_W,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we_a,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    input  logic              frame_release,
    output logic [7:0]        frame_count,
    output logic              sum_err
);

    loader_state_t     state;
    logic [ADDR_W-1:0] cnt;
    logic              xfer;
    logic              last_byte;

    assign xfer      = in_valid && in_ready;
    assign last_byte = (cnt == ADDR_W'(DEPTH - 1));

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic sum_match;
    logic sum_clear;
    logic sum_err_q;

    // Accumulator restarts whenever a fresh frame begins: after a release or a rejected frame.
    assign sum_clear = (state == READY && frame_release) || (state == SUM && xfer && !sum_match);

    frame_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (sum_clear),
        .add_en   (state == FILL && xfer),
        .add_data (in_data),
        .cmp_data (in_data),
        .match    (sum_match)
    );

    assign sum_err = sum_err_q;
`else
    assign sum_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FILL;
            cnt         <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            we_a        <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_count <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            sum_err_q   <= 1'b0;
`endif
        end else begin
            we_a <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            sum_err_q <= 1'b0;
`endif
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        we_a    <= 1'b1;
                        wr_addr <= cnt;
                        wr_data <= in_data;
                        if (last_byte) begin
                            cnt <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            state <= SUM;
`else
                            state    <= LAST;
                            in_ready <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef FRAME_LOADER_CHECKSUM_EN
                SUM: begin
                    if (xfer) begin
                        if (sum_match) begin
                            state    <= LAST;
                            in_ready <= 1'b0;
                        end else begin
                            state     <= FILL;
                            sum_err_q <= 1'b1;
                        end
                    end
                end
`endif
                // One extra cycle lets the final write land before busy drops.
                LAST: begin
                    state       <= READY;
                    busy        <= 1'b0;
                    frame_count <= frame_count + 8'd1;
                end
                READY: begin
                    if (frame_release) begin
                        state    <= FILL;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        cnt      <= '0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - randomized scoreboard bench for frame_loader (honours FRAME_LOADER_CHECKSUM_EN)
module tb_frame_loader;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       we_a;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_release;
    logic [7:0] frame_count;
    logic       sum_err;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] exp_q[$];
    int          model_cnt = 0;
    logic [7:0]  exp_fc = 8'd0;
    logic [7:0]  frame_bytes[DEPTH];

    always #5 clk = ~clk;

    frame_loader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .we_a          (we_a),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .frame_release (frame_release),
        .frame_count   (frame_count),
        .sum_err       (sum_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every memory write must match the oldest accepted byte.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e[13:8]));
                check("wr_data", 32'(wr_data), 32'(e[7:0]));
            end
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_we_a", 32'(we_a), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_sum_err", 32'(sum_err), 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_ready: got in_ready 0 expected 1 within 5 cycles");
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gaps, input bit to_mem);
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            frame_release = gaps && ($urandom_range(0, 7) == 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                if (in_ready) begin
                    if (to_mem) begin
                        exp_q.push_back({6'(model_cnt), d});
                        model_cnt++;
                    end
                    return;
                end
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no handshake expected one within 200 cycles");
    endtask

    task automatic fill_frame(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       frame_bytes[i] = 8'(i);
                1:       frame_bytes[i] = 8'($urandom);
                default: frame_bytes[i] = 8'h01;
            endcase
        end
    endtask

    task automatic send_frame(input bit gaps, input bit bad);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(frame_bytes[i], gaps, 1'b1);
            s = s + frame_bytes[i];
        end
        model_cnt = 0;
`ifdef FRAME_LOADER_CHECKSUM_EN
        send_byte(bad ? s + 8'd1 : s, gaps, 1'b0);
`endif
        @(negedge clk);
        in_valid      = 1'b0;
        frame_release = 1'b0;
        check("busy_after_last", 32'(busy), 1);
        if (bad) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
            check("sum_err_pulse", 32'(sum_err), 1);
            check("in_ready_after_bad", 32'(in_ready), 1);
            check("fc_after_bad", 32'(frame_count), 32'(exp_fc));
            @(negedge clk);
            check("sum_err_one_cycle", 32'(sum_err), 0);
            check("busy_after_bad", 32'(busy), 1);
`endif
            return;
        end
        check("sum_err_quiet", 32'(sum_err), 0);
        @(negedge clk);
        exp_fc = exp_fc + 8'd1;
        check("busy_fall", 32'(busy), 0);
        check("frame_count", 32'(frame_count), 32'(exp_fc));
        check("in_ready_ready", 32'(in_ready), 0);
    endtask

    task automatic do_release();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            check("ready_blocks", 32'(in_ready), 0);
        end
        @(negedge clk);
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
        in_valid      = 1'b0;
        check("release_busy", 32'(busy), 1);
        check("release_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        in_data       = 8'd0;
        frame_release = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset_n = 1'b1;
        wait_ready();

        fill_frame(0);
        send_frame(1'b0, 1'b0);

        do_release();
        fill_frame(1);
        send_frame(1'b1, 1'b0);

`ifdef FRAME_LOADER_CHECKSUM_EN
        do_release();
        fill_frame(2);
        send_frame(1'b0, 1'b0);
        do_release();
        fill_frame(2);
        send_frame(1'b0, 1'b1);
        fill_frame(1);
        send_frame(1'b1, 1'b0);
`endif

        // Abandon a frame partway through with a one-cycle reset.
        do_release();
        fill_frame(1);
        for (int i = 0; i < 30; i++) send_byte(frame_bytes[i], 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        check("queue_after_reset", 32'(exp_q.size()), 0);
        reset_n   = 1'b1;
        model_cnt = 0;
        exp_fc    = 8'd0;
        wait_ready();

        for (int f = 0; f < 256; f++) begin
            fill_frame(1);
            send_frame(1'b0, 1'b0);
            do_release();
        end
        check("fc_wrapped", 32'(frame_count), 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
# frame_loader

Input stage ahead of the frame control unit. Accepts a byte stream over a valid/ready handshake, writes one 64-byte frame into buffer memory A through its write port, and drives `busy` high while the frame is incomplete. Once the frame is stored it releases `busy`, so the control unit can start its READ sweep. It then blocks further input until that unit signals the frame is consumed.

## Interface
- `DEPTH`, default 64: bytes per frame. Must equal the control unit's A-address span.
- `DATA_W`, default 8: byte width.
- `ADDR_W`, default $clog2(DEPTH) = 6: write address width.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_data` in DATA_W: stream byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `we_a` out 1: memory A write enable.
- `wr_addr` out ADDR_W: memory A write address.
- `wr_data` out DATA_W: memory A write data.
- `busy` out 1: frame incomplete. Connects to the control unit `busy` input.
- `frame_release` in 1: one-cycle pulse, frame consumed. Wired to control unit `data_rdy`.
- `frame_count` out 8: completed frames, modulo 256.
- `sum_err` out 1: one-cycle checksum-mismatch pulse. Tied 0 without the macro.

## Operation
- States:
  - FILL: `in_ready` = 1.
  - LAST: final write in flight.
  - SUM: macro only, `in_ready` = 1.
  - READY: `in_ready` = 0, `busy` = 0.
- Handshake: a transfer occurs when `in_valid` && `in_ready`. There is no other way to transfer data. Bytes are never dropped; a stalled producer simply waits.
- FILL: each transfer writes `in_data` at address `cnt`, then `cnt` increments.
- On the transfer with `cnt` == DEPTH-1:
  - without the macro → LAST;
  - with the macro → SUM.
- LAST → READY after one cycle. `frame_count` increments on entry to READY.
- READY: waits for `frame_release`, then → FILL with `cnt` = 0 and `busy` = 1.
- `frame_release` outside READY is ignored.
- `cnt` is ADDR_W wide and never wraps within a frame. It resets to 0 on every FILL entry.
- Reset mid-operation: all state clears and the partial frame is abandoned. The next frame starts at address 0.

## Timing
- Reset values:
  - `in_ready` = 0 while `reset_n` = 0, then 1 from the first cycle after release (state FILL);
  - `busy` = 1;
  - `we_a` = 0, `wr_addr` = 0, `wr_data` = 0;
  - `frame_count` = 0, `sum_err` = 0.
- Write port is registered: a transfer in cycle N drives `we_a` = 1 and the address/data in cycle N+1. The memory captures the write at the end of N+1.
- `busy` is registered. Without the macro it falls in cycle N+2 after the last data handshake in cycle N, so the write has landed before the control unit reads address 0.
- `busy` rises in the cycle after `frame_release` is sampled in READY. `in_ready` rises in that same cycle.
- Back-to-back transfers sustain 1 byte/cycle.
- Simultaneous `frame_release` and `in_valid` in READY: the release wins. No byte is accepted until the next cycle.

## Configuration
- Macro: `FRAME_LOADER_CHECKSUM_EN`.
- Defined:
  - each frame carries a trailing 65th byte;
  - the loader accumulates an 8-bit modulo-256 sum of the DEPTH data bytes;
  - the trailing byte transfers in SUM and is not written to memory;
  - match → LAST-equivalent timing (`busy` falls 2 cycles after the checksum handshake, then READY);
  - mismatch → `sum_err` pulses 1 cycle, state returns to FILL with `cnt` = 0, `busy` stays 1, `frame_count` is unchanged.
- Undefined: no SUM state, no accumulator, `sum_err` tied 0.

## Structure
- Shared package `frame_pkg`:
  - state enum `loader_state_t` (FILL, LAST, SUM, READY);
  - constants `FRAME_DEPTH` = 64, `FRAME_DATA_W` = 8.
  - The control unit and this block both use these.
- One sub-module, `frame_checksum`: 8-bit accumulator with clear, add-enable and compare output. It is instantiated only under the macro.

## Test plan
- Reset, then 64 back-to-back bytes 0x00..0x3F → 64 `we_a` pulses with `wr_addr` = `wr_data` = i. `busy` falls 2 cycles after the last handshake. `frame_count` = 1.
- In READY with `in_valid` held 1 → `in_ready` = 0 and no `we_a`. A `frame_release` pulse → `busy` = 1 and `in_ready` = 1 the next cycle. The next byte lands at `wr_addr` 0.
- `in_valid` toggled randomly during FILL → `wr_addr` advances only on handshakes. Data order is preserved.
- Macro defined, 64 × 0x01 then 0x40 → `busy` falls, `frame_count` increments. Then 64 × 0x01 then 0x41 → one `sum_err` pulse, `busy` stays 1, and the following frame writes from address 0.
- `reset_n` low for 1 cycle after the 30th byte → all outputs return to reset values. The next frame starts at `wr_addr` 0.
- 256 complete frames with releases → `frame_count` wraps 0xFF→0x00.
